// File: rtl/tmp_rx_pkg.sv
// tmp_rx_pkg: shared state encoding, default sizes and accumulator width for the result receiver.
package tmp_rx_pkg;
  typedef enum logic [1:0] {ARMED, INTEGRATE, ACCUM, PRESENT} state_t;
  localparam int CNT_W_DEF = 10;
  localparam int AVG_LOG2_DEF = 2;
  function automatic int acc_w(input int cnt_w, input int avg_log2);
    return cnt_w + 1 + avg_log2;
  endfunction
endpackage

// File: rtl/tmp_updn_cnt.sv
// tmp_updn_cnt: saturating up/down counter pair; o_sat flags a count lost to saturation.
module tmp_updn_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_dir,
  output logic [CNT_W-1:0] o_up,
  output logic [CNT_W-1:0] o_dn,
  output logic             o_sat
);
  logic w_up_full, w_dn_full;
  assign w_up_full = &o_up;
  assign w_dn_full = &o_dn;
  assign o_sat = i_en & ~i_clr & (i_dir ? w_up_full : w_dn_full);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_up <= '0;
      o_dn <= '0;
    end else if (i_clr) begin
      o_up <= '0;
      o_dn <= '0;
    end else if (i_en) begin
      if (i_dir && !w_up_full) o_up <= o_up + 1'b1;
      if (!i_dir && !w_dn_full) o_dn <= o_dn + 1'b1;
    end
  end
endmodule

// File: rtl/tmp_result_rx.sv
// tmp_result_rx: counts comparator decisions per frame, averages 2^AVG_LOG2 frames, presents a signed code.
module tmp_result_rx
  import tmp_rx_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmp,
  input  logic           PI2,
  input  logic           PA,
  input  logic           PB,
  input  logic           PC,
  input  logic           PD,
  input  logic           preChrg,
  input  logic           data_ready,
  output logic [CNT_W:0] data,
  output logic           data_valid,
  output logic           overflow,
  output logic           busy
);
  localparam int ACC_W = acc_w(CNT_W, AVG_LOG2);
  localparam logic [AVG_LOG2-1:0] LAST = '1;
  state_t r_state, w_next;
  logic r_ph, r_pc, r_sat, r_busy, r_valid, r_ovf;
  logic [CNT_W:0] r_data;
  logic [AVG_LOG2-1:0] r_frame;
  logic signed [ACC_W-1:0] r_acc, w_acc_next, w_shift;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W-1:0] w_up, w_dn;
  logic w_ph, w_fe, w_pc_fall, w_pc_rise, w_clr, w_en, w_abort, w_take, w_sat, w_last;
  assign w_ph = PA & PB & PC & PD;
  assign w_fe = w_ph & ~r_ph;
  assign w_pc_fall = ~preChrg & r_pc;
  assign w_pc_rise = preChrg & ~r_pc;
  assign w_last = (r_state == ACCUM) && (r_frame == LAST);
  assign w_diff = $signed({1'b0, w_up}) - $signed({1'b0, w_dn});
  assign w_acc_next = r_acc + {{AVG_LOG2{w_diff[CNT_W]}}, w_diff};
  assign w_shift = w_acc_next >>> AVG_LOG2;
  assign data = r_data;
  assign data_valid = r_valid;
  assign overflow = r_ovf;
  assign busy = r_busy;
  tmp_updn_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(reset), .i_clr(w_clr), .i_en(w_en), .i_dir(cmp),
    .o_up(w_up), .o_dn(w_dn), .o_sat(w_sat)
  );
  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_en    = 1'b0;
    w_abort = 1'b0;
    w_take  = 1'b0;
    case (r_state)
      ARMED: if (w_pc_fall) begin
        w_next = INTEGRATE;
        w_clr  = 1'b1;
      end
      INTEGRATE: begin
        w_en = PI2;
        // restart beats frame end: the whole average is thrown away
        if (w_pc_rise) begin
          w_next  = ARMED;
          w_clr   = 1'b1;
          w_abort = 1'b1;
        end else if (w_fe) w_next = ACCUM;
      end
      ACCUM: w_next = (r_frame == LAST) ? PRESENT : ARMED;
      PRESENT: if (data_ready) begin
        w_next = ARMED;
        w_take = 1'b1;
      end
      default: w_next = ARMED;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARMED;
      r_ph    <= 1'b0;
      r_pc    <= 1'b0;
      r_sat   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_data  <= '0;
      r_frame <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      r_ph    <= w_ph;
      r_pc    <= preChrg;
      r_busy  <= (w_next == INTEGRATE) || (w_next == ACCUM);
      r_valid <= w_next == PRESENT;
      r_sat   <= (w_abort || w_take) ? 1'b0 : (r_sat | w_sat);
      if (w_abort || w_take) r_acc <= '0;
      else if (r_state == ACCUM) r_acc <= w_acc_next;
      if (w_abort || w_last) r_frame <= '0;
      else if (r_state == ACCUM) r_frame <= r_frame + 1'b1;
      if (w_last) begin
        r_data <= w_shift[CNT_W:0];
        r_ovf  <= r_sat;
      end else if (r_state == PRESENT && w_fe) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tmp_result_rx.sv
// tb_tmp_result_rx: scoreboard bench for tmp_result_rx (default sizes plus a CNT_W=4 instance).
module tb_tmp_result_rx;
  import tmp_rx_pkg::*;
  typedef struct {logic [10:0] d; logic ov;} exp_t;
  logic clk = 1'b0;
  logic reset, cmp, PI2, PA, PB, PC, PD, preChrg, data_ready;
  logic [10:0] data;
  logic data_valid, overflow, busy;
  logic [4:0] data4;
  logic dv4, ov4, busy4;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  tmp_result_rx dut (
    .clk(clk), .reset(reset), .cmp(cmp), .PI2(PI2), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .preChrg(preChrg), .data_ready(data_ready), .data(data), .data_valid(data_valid),
    .overflow(overflow), .busy(busy)
  );
  tmp_result_rx #(.CNT_W(4), .AVG_LOG2(2)) dut4 (
    .clk(clk), .reset(reset), .cmp(cmp), .PI2(PI2), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .preChrg(preChrg), .data_ready(data_ready), .data(data4), .data_valid(dv4),
    .overflow(ov4), .busy(busy4)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic phases(input logic v);
    PA = v; PB = v; PC = v; PD = v;
  endtask
  task automatic frame(input int nu, input int nd, input bit ov, input bit chk);
    preChrg = 1'b1; tick;
    preChrg = 1'b0; tick;
    for (int i = 0; i < nu + nd - (ov ? 1 : 0); i++) begin
      PI2 = 1'b1; cmp = (i < nu); tick;
    end
    PI2 = ov; cmp = (nd == 0); phases(1'b1); tick;
    if (chk) begin
      checks++;
      if (data_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL fe_cycle: data_valid=%b busy=%b, required 0 and 1", data_valid, busy);
      end
    end
    PI2 = 1'b0; cmp = 1'b0; phases(1'b0); tick;
    if (chk) begin
      checks++;
      if (data_valid !== 1'b1) begin
        failures++;
        $display("FAIL valid_latency: data_valid=%b two cycles after fe, required 1", data_valid);
      end
    end
  endtask
  task automatic run_word(input int nu, input int nd, input bit ov, input bit ovf);
    exp_t e;
    e.d = 11'((4 * (nu - nd)) >>> 2);
    e.ov = ovf;
    sb.push_back(e);
    for (int f = 0; f < 4; f++) frame(nu, nd, ov, f == 3);
  endtask
  task automatic collect(input string name);
    exp_t e;
    int n = 0;
    while (data_valid !== 1'b1 && n < 200) begin tick; n++; end
    checks++;
    if (data_valid !== 1'b1 || sb.size() == 0) begin
      failures++;
      $display("FAIL %s_wait: data_valid=%b queued=%0d, required valid word", name, data_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (data !== e.d) begin
      failures++;
      $display("FAIL %s_data: data=%h, required %h", name, data, e.d);
    end
    checks++;
    if (overflow !== e.ov) begin
      failures++;
      $display("FAIL %s_ovf: overflow=%b, required %b", name, overflow, e.ov);
    end
    data_ready = 1'b1; tick; data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: data_valid=%b after handshake, required 0", name, data_valid);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; cmp = 0; PI2 = 0; phases(1'b0); preChrg = 0; data_ready = 0;
    tick; tick;
    checks++;
    if ({data, data_valid, overflow, busy} !== 14'd0) begin
      failures++;
      $display("FAIL reset: data=%h dv=%b ovf=%b busy=%b, required all 0", data, data_valid, overflow, busy);
    end
    reset = 1'b0; tick;
  endtask
  task automatic test_single;
    run_word(12, 8, 1'b0, 1'b0);
    collect("single");
  endtask
  task automatic test_negative;
    run_word(5, 15, 1'b1, 1'b0);
    checks++;
    if (data !== 11'h7F6) begin
      failures++;
      $display("FAIL negative_code: data=%h, required 7f6", data);
    end
    collect("negative");
  endtask
  task automatic test_async_reset;
    preChrg = 1'b1; tick;
    preChrg = 1'b0; tick;
    PI2 = 1'b1; cmp = 1'b1; tick; tick; tick;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({data, data_valid, overflow, busy} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset: data=%h dv=%b ovf=%b busy=%b, required all 0", data, data_valid, overflow, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0; PI2 = 1'b0; cmp = 1'b0; tick;
    run_word(9, 3, 1'b0, 1'b0);
    collect("after_reset");
  endtask
  task automatic test_saturation;
    exp_t e;
    frame(20, 0, 1'b0, 1'b0);
    checks++;
    if (dut4.u_cnt.o_up !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold: up_cnt=%0d, required 15", dut4.u_cnt.o_up);
    end
    e.d = 11'd5; e.ov = 1'b0;
    sb.push_back(e);
    frame(2, 2, 1'b0, 1'b0);
    frame(2, 2, 1'b0, 1'b0);
    frame(2, 2, 1'b0, 1'b1);
    checks++;
    if (dv4 !== 1'b1 || data4 !== 5'd3 || ov4 !== 1'b1) begin
      failures++;
      $display("FAIL sat_word: dv=%b data=%h ovf=%b, required 1 03 1", dv4, data4, ov4);
    end
    collect("sat_wide");
  endtask
  task automatic test_backpressure;
    logic [10:0] d0;
    run_word(12, 8, 1'b0, 1'b1);
    d0 = data;
    for (int k = 0; k < 3; k++) begin
      phases(1'b1); tick; phases(1'b0); tick;
      checks++;
      if (data_valid !== 1'b1 || data !== d0 || overflow !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d: dv=%b data=%h ovf=%b, required 1 %h 1", k, data_valid, data, overflow, d0);
      end
    end
    collect("backpressure");
    checks++;
    if (dut.r_state !== ARMED) begin
      failures++;
      $display("FAIL bp_state: state=%0d, required ARMED", dut.r_state);
    end
  endtask
  task automatic test_back_to_back;
    data_ready = 1'b1;
    run_word(10, 6, 1'b0, 1'b0);
    collect("b2b_first");
    data_ready = 1'b1;
    run_word(3, 9, 1'b0, 1'b0);
    collect("b2b_second");
  endtask
  task automatic test_restart;
    frame(30, 0, 1'b0, 1'b0);
    frame(30, 0, 1'b0, 1'b0);
    preChrg = 1'b1; tick;
    preChrg = 1'b0; tick;
    for (int i = 0; i < 5; i++) begin PI2 = 1'b1; cmp = 1'b1; tick; end
    preChrg = 1'b1; tick;
    PI2 = 1'b0;
    checks++;
    if (busy !== 1'b0 || dut.r_state !== ARMED) begin
      failures++;
      $display("FAIL restart_abort: busy=%b state=%0d, required 0 and ARMED", busy, dut.r_state);
    end
    run_word(10, 10, 1'b0, 1'b0);
    collect("restart");
  endtask
  initial begin
    test_reset;
    test_single;
    test_negative;
    test_async_reset;
    test_saturation;
    test_backpressure;
    test_back_to_back;
    test_restart;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d words never presented, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
